// File: rtl/uart_tx_packetizer.sv
// uart_tx_packetizer
// Purpose: serialise an N_WORDS-word result bus onto a UART TX line, word 0 (LSBs)
// first, with a runtime baud divisor, runtime parity and a fixed PACKET_SIZE frame
// (start, data LSB-first, optional parity, stop/padding ones).
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   s_valid/s_ready input handshake; s_data, clks_per_pulse, parity_mode latched on transfer
//   s_data          W_BUS-bit bus, word i = s_data[i*BITS_PER_WORD +: BITS_PER_WORD]
//   clks_per_pulse  clocks per UART bit (0 behaves as 1)
//   parity_mode     0 none, 1 even, 2 odd, 3 none
//   tx              registered UART line, idles high
//   busy            transaction in progress
//   done            1-cycle pulse on the first idle cycle after a transaction
module uart_tx_packetizer #(
  parameter int unsigned BITS_PER_WORD = 8,
  parameter int unsigned N_WORDS       = 16,
  parameter int unsigned W_BUS         = N_WORDS * BITS_PER_WORD,
  parameter int unsigned PACKET_SIZE   = 13,
  parameter int unsigned W_DIV         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [W_BUS-1:0]   s_data,
  input  logic [W_DIV-1:0]   clks_per_pulse,
  input  logic [1:0]         parity_mode,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W_BIT  = $clog2(PACKET_SIZE);
  localparam int unsigned W_WORD = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned PAR_IDX = BITS_PER_WORD + 1;

  localparam logic [W_BIT-1:0]  LAST_BIT  = W_BIT'(PACKET_SIZE - 1);
  localparam logic [W_WORD-1:0] LAST_WORD = W_WORD'(N_WORDS - 1);

  // Elaboration-time parameter sanity
  if (PACKET_SIZE < BITS_PER_WORD + 3) begin : g_chk_packet
    $error("PACKET_SIZE must be at least BITS_PER_WORD+3");
  end
  if ((W_BUS % BITS_PER_WORD) != 0) begin : g_chk_bus
    $error("W_BUS must be a multiple of BITS_PER_WORD");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t             r_state;
  logic [W_BUS-1:0]   r_data;
  logic [W_DIV-1:0]   r_div;
  logic [1:0]         r_parity_mode;
  logic [W_DIV-1:0]   r_pulse;
  logic [W_BIT-1:0]   r_bit;
  logic [W_WORD-1:0]  r_word;
  logic               r_tx;
  logic               r_done;

  logic [BITS_PER_WORD-1:0] w_cur_word;
  logic                     w_parity;
  logic [PACKET_SIZE-1:0]   w_frame;
  logic                     w_pulse_wrap;
  logic                     w_bit_wrap;
  logic                     w_last;
  logic [W_BIT-1:0]         w_next_bit;

  // The word in flight always sits in the low bits; r_data shifts down per word
  assign w_cur_word = r_data[BITS_PER_WORD-1:0];

  // Current word's full line frame, indexed by bit position
  always_comb begin
    w_parity = (r_parity_mode == 2'd2) ? ~^w_cur_word : ^w_cur_word;
    w_frame  = '1;
    w_frame[0] = 1'b0;
    w_frame[BITS_PER_WORD:1] = w_cur_word;
    if ((r_parity_mode == 2'd1) || (r_parity_mode == 2'd2)) begin
      w_frame[PAR_IDX] = w_parity;
    end
  end

  // Counter wrap conditions and the bit position that the next cycle will drive
  always_comb begin
    w_pulse_wrap = (r_pulse == (r_div - W_DIV'(1)));
    w_bit_wrap   = w_pulse_wrap && (r_bit == LAST_BIT);
    w_last       = w_bit_wrap && (r_word == LAST_WORD);
    w_next_bit   = r_bit;
    if (w_pulse_wrap) begin
      w_next_bit = (r_bit == LAST_BIT) ? '0 : (r_bit + W_BIT'(1));
    end
  end

  // FSM, counters and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_data        <= '0;
      r_div         <= '0;
      r_parity_mode <= '0;
      r_pulse       <= '0;
      r_bit         <= '0;
      r_word        <= '0;
      r_tx          <= 1'b1;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_valid) begin
            r_state       <= S_SEND;
            r_data        <= s_data;
            r_div         <= (clks_per_pulse == '0) ? W_DIV'(1) : clks_per_pulse;
            r_parity_mode <= parity_mode;
            r_pulse       <= '0;
            r_bit         <= '0;
            r_word        <= '0;
            r_tx          <= 1'b0;
          end
        end
        S_SEND: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_pulse <= '0;
            r_bit   <= '0;
            r_word  <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_pulse <= w_pulse_wrap ? '0 : (r_pulse + W_DIV'(1));
            r_bit   <= w_next_bit;
            if (w_bit_wrap) begin
              r_word <= r_word + W_WORD'(1);
              r_data <= r_data >> BITS_PER_WORD;
            end
            // On a word boundary the next bit is the start bit, so the old word is fine here
            r_tx <= w_frame[w_next_bit];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready = (r_state == S_IDLE);
  assign busy    = (r_state != S_IDLE);
  assign tx      = r_tx;
  assign done    = r_done;

endmodule

// File: tb/tb_uart_tx_packetizer.sv
// tb_uart_tx_packetizer
// Purpose: directed self-checking bench for uart_tx_packetizer with N_WORDS=2.
// Every line cycle is compared against hand-built 13-bit frames.
module tb_uart_tx_packetizer;

  localparam int unsigned BPW = 8;
  localparam int unsigned NW  = 2;
  localparam int unsigned WB  = NW * BPW;
  localparam int unsigned PS  = 13;
  localparam int unsigned WD  = 16;

  // Hand-computed frames, bit b of the vector is line bit b
  localparam logic [PS-1:0] F3C_N = {4'b1111, 8'h3C, 1'b0};
  localparam logic [PS-1:0] FA5_N = {4'b1111, 8'hA5, 1'b0};
  localparam logic [PS-1:0] F3C_E = {3'b111, 1'b0, 8'h3C, 1'b0};
  localparam logic [PS-1:0] FA5_E = {3'b111, 1'b0, 8'hA5, 1'b0};
  localparam logic [PS-1:0] F3C_O = {3'b111, 1'b1, 8'h3C, 1'b0};
  localparam logic [PS-1:0] FA5_O = {3'b111, 1'b1, 8'hA5, 1'b0};

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [WB-1:0] s_data;
  logic [WD-1:0] clks_per_pulse;
  logic [1:0]    parity_mode;
  logic          tx;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_packetizer #(
    .BITS_PER_WORD (BPW),
    .N_WORDS       (NW),
    .W_BUS         (WB),
    .PACKET_SIZE   (PS),
    .W_DIV         (WD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .clks_per_pulse (clks_per_pulse),
    .parity_mode    (parity_mode),
    .tx             (tx),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic obs, input logic exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Frame of one byte: start 0, data LSB first, parity (modes 1/2) at bit 9, ones after
  function automatic logic [PS-1:0] mk_frame(input logic [7:0] b, input logic [1:0] pm);
    logic [PS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    if (pm == 2'd1) f[9] = ^b;
    if (pm == 2'd2) f[9] = ~^b;
    return f;
  endfunction

  // Checks idle state, presents a request, and returns just after the transfer edge
  task automatic drive_req(input logic [WB-1:0] d, input logic [WD-1:0] cpp, input logic [1:0] pm);
    @(negedge clk);
    check("idle_tx", tx, 1'b1);
    check("idle_ready", s_ready, 1'b1);
    check("idle_done", done, 1'b0);
    s_valid        = 1'b1;
    s_data         = d;
    clks_per_pulse = cpp;
    parity_mode    = pm;
    @(posedge clk);
  endtask

  // Checks every line cycle of a transaction, then the done cycle.
  // After the first cycle the inputs are either scrambled (chain=0) or loaded with
  // the next request held valid (chain=1).
  task automatic check_txn(input logic [PS-1:0] f0, input logic [PS-1:0] f1, input int div,
                           input bit chain, input logic [WB-1:0] nd, input logic [WD-1:0] ncpp,
                           input logic [1:0] npm, input string tag);
    int   total;
    int   w;
    int   b;
    logic exp_b;
    total = NW * PS * div;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      w = k / (PS * div);
      b = (k / div) % PS;
      exp_b = (w == 0) ? f0[b] : f1[b];
      check($sformatf("%s_tx_w%0d_b%0d_k%0d", tag, w, b, k), tx, exp_b);
      if (k == 0 || k == total - 1) check($sformatf("%s_busy_k%0d", tag, k), busy, 1'b1);
      if (k == 0) begin
        if (chain) begin
          s_valid        = 1'b1;
          s_data         = nd;
          clks_per_pulse = ncpp;
          parity_mode    = npm;
        end else begin
          s_valid        = 1'b0;
          s_data         = ~s_data;
          clks_per_pulse = 16'd7;
          parity_mode    = ~parity_mode;
        end
      end
    end
    @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_done_ready"}, s_ready, 1'b1);
    check({tag, "_done_tx"}, tx, 1'b1);
  endtask

  logic [WB-1:0] v_data [3];
  logic [WD-1:0] v_div  [3];
  logic [1:0]    v_pm   [3];

  initial begin
    rst            = 1'b1;
    s_valid        = 1'b0;
    s_data         = '0;
    clks_per_pulse = '0;
    parity_mode    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_ready", s_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b0;

    // Basic frame, no parity, div 4: 104 busy cycles then done
    drive_req(16'hA53C, 16'd4, 2'd0);
    check_txn(F3C_N, FA5_N, 4, 1'b0, '0, '0, '0, "t1_none");

    // Even and odd parity
    drive_req(16'hA53C, 16'd4, 2'd1);
    check_txn(F3C_E, FA5_E, 4, 1'b0, '0, '0, '0, "t2_even");
    drive_req(16'hA53C, 16'd3, 2'd2);
    check_txn(F3C_O, FA5_O, 3, 1'b0, '0, '0, '0, "t2_odd");

    // Divisor 0 acts as 1; mid-transaction change to 7 is ignored
    drive_req(16'hA53C, 16'd0, 2'd0);
    check_txn(F3C_N, FA5_N, 1, 1'b0, '0, '0, '0, "t3_div0");

    // Parity mode 3 behaves as none
    drive_req(16'h7E01, 16'd2, 2'd3);
    check_txn({4'b1111, 8'h01, 1'b0}, {4'b1111, 8'h7E, 1'b0}, 2, 1'b0, '0, '0, '0, "t3_pm3");

    // s_valid held with new data while busy: accepted on the done cycle, no gap
    drive_req(16'h1234, 16'd2, 2'd1);
    check_txn(mk_frame(8'h34, 2'd1), mk_frame(8'h12, 2'd1), 2, 1'b1,
              16'hBEEF, 16'd3, 2'd2, "t4_first");
    check_txn(mk_frame(8'hEF, 2'd2), mk_frame(8'hBE, 2'd2), 3, 1'b0, '0, '0, '0, "t4_second");

    // Reset during word 1, bit 5
    drive_req(16'hA53C, 16'd2, 2'd0);
    for (int k = 0; k < (PS + 5) * 2; k++) begin
      @(negedge clk);
      if (k == 0) s_valid = 1'b0;
    end
    @(negedge clk);
    check("t5_pre_rst_tx", tx, FA5_N[5]);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_tx", tx, 1'b1);
    check("t5_rst_ready", s_ready, 1'b1);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    rst = 1'b0;
    drive_req(16'h5AC3, 16'd5, 2'd2);
    check_txn(mk_frame(8'hC3, 2'd2), mk_frame(8'h5A, 2'd2), 5, 1'b0, '0, '0, '0, "t5_fresh");

    // Assorted data / divisors / parity
    v_data[0] = 16'h00FF; v_div[0] = 16'd1;  v_pm[0] = 2'd1;
    v_data[1] = 16'h8001; v_div[1] = 16'd20; v_pm[1] = 2'd2;
    v_data[2] = 16'hFFFF; v_div[2] = 16'd7;  v_pm[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      drive_req(v_data[i], v_div[i], v_pm[i]);
      check_txn(mk_frame(v_data[i][7:0], v_pm[i]), mk_frame(v_data[i][15:8], v_pm[i]),
                int'(v_div[i]), 1'b0, '0, '0, '0, $sformatf("t6_%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
